// File: rtl/utemp_pkg.sv
// Shared types and helpers for the unary-temporal multiplier array.
package utemp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Magnitude bits of a sign-magnitude operand of the given width.
  function automatic int unsigned mag_of(input int unsigned width);
    return width - 1;
  endfunction

  // Multiply period length in cycles for the given operand width.
  function automatic int unsigned period_of(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  // Reverse the low 'width' bits of value; bits above width come back 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value,
                                         input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (b < width) r[b] = value[width - 1 - b];
    end
    return r;
  endfunction

endpackage

// File: rtl/utemp_rng.sv
// Bit-reversed counter used as the shared low-discrepancy RNG.
module utemp_rng
  import utemp_pkg::*;
#(
  parameter int MAG = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  input  logic           i_clr,
  output logic [MAG-1:0] o_rand
);

  logic [MAG-1:0] r_k;

  // Counter advances once per input-stream one; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_k <= '0;
    else if (i_clr) r_k <= '0;
    else if (i_en)  r_k <= r_k + 1'b1;
  end

  assign o_rand = MAG'(bitrev(32'(r_k), MAG));

endmodule

// File: rtl/utemp_mul_array.sv
// Unary-temporal border multiplier: one sign-magnitude activation is
// streamed as a thermometer code to NUM_CH rate-coded weight channels.
// Optional per-channel saturating accumulators: define UTEMP_ACC_EN.
module utemp_mul_array
  import utemp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_CH = 4,
  parameter int ACC_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    clr,
  input  logic [WIDTH-1:0]        i_data_i,
  input  logic [NUM_CH*WIDTH-1:0] i_data_w,
  output logic [NUM_CH-1:0]       o_bit,
  output logic [NUM_CH-1:0]       o_sign,
  output logic                    o_busy,
  output logic                    o_done
`ifdef UTEMP_ACC_EN
  ,
  output logic [NUM_CH*ACC_W-1:0] o_acc
`endif
);

  localparam int unsigned    MAG    = mag_of(WIDTH);
  localparam int unsigned    P      = period_of(WIDTH);
  localparam logic [MAG-1:0] T_LAST = MAG'(P - 1);

  state_t              r_state;
  logic [MAG-1:0]      r_t;
  logic [MAG-1:0]      r_mag_i;
  logic [MAG-1:0]      r_w_mag [NUM_CH];
  logic [NUM_CH-1:0]   r_sign;
  logic                r_busy;
  logic                r_done;

  logic                w_bit_i;
  logic [MAG-1:0]      w_rand;
  logic [NUM_CH-1:0]   w_bit;

  // Control FSM: operand latch, period timer and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_mag_i <= '0;
      r_sign  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) r_w_mag[c] <= '0;
    end else if (clr) begin
      r_state <= IDLE;
      r_t     <= '0;
      r_sign  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= RUN;
            r_t     <= '0;
            r_mag_i <= i_data_i[MAG-1:0];
            r_busy  <= 1'b1;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              r_w_mag[c] <= i_data_w[c*WIDTH +: MAG];
              r_sign[c]  <= i_data_i[WIDTH-1] ^ i_data_w[c*WIDTH + WIDTH - 1];
            end
          end
        end
        RUN: begin
          if (r_t == T_LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_t <= r_t + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_sign  <= '0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign w_bit_i = r_busy & (r_t < r_mag_i);

  // k is held at zero outside RUN, so every period starts the RNG from 0.
  utemp_rng #(
    .MAG (MAG)
  ) u_rng (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_en   (w_bit_i),
    .i_clr  (clr | ~r_busy),
    .o_rand (w_rand)
  );

  // Per-channel rate-coded gate of the input stream.
  always_comb begin
    w_bit = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_bit[c] = w_bit_i & (r_w_mag[c] > w_rand);
    end
  end

  assign o_bit  = w_bit;
  assign o_sign = r_sign;
  assign o_busy = r_busy;
  assign o_done = r_done;

`ifdef UTEMP_ACC_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc [NUM_CH];

  // Signed saturating count of product bits, persistent across periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
    end else if (clr) begin
      for (int unsigned c = 0; c < NUM_CH; c++) r_acc[c] <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (w_bit[c]) begin
          if (!r_sign[c]) begin
            if (r_acc[c] != ACC_MAX) r_acc[c] <= r_acc[c] + ACC_W'(1);
          end else begin
            if (r_acc[c] != ACC_MIN) r_acc[c] <= r_acc[c] - ACC_W'(1);
          end
        end
      end
    end
  end

  // Flatten accumulators onto the output bus.
  always_comb begin
    o_acc = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      o_acc[c*ACC_W +: ACC_W] = r_acc[c];
    end
  end
`else
  // ACC_W only sizes the accumulators; keep it referenced in this build.
  if (ACC_W < 1) begin : g_acc_w_unused
  end
`endif

endmodule

// File: tb/tb_utemp_mul_array.sv
// Directed bench for utemp_mul_array (WIDTH=8, NUM_CH=4).
module tb_utemp_mul_array;

  localparam int WIDTH  = 8;
  localparam int NUM_CH = 4;
  localparam int ACC_W  = 6;
  localparam int P      = 128;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        clr;
  logic [7:0]  i_data_i;
  logic [31:0] i_data_w;
  logic [3:0]  o_bit;
  logic [3:0]  o_sign;
  logic        o_busy;
  logic        o_done;
`ifdef UTEMP_ACC_EN
  logic [NUM_CH*ACC_W-1:0] o_acc;
`endif

  utemp_mul_array #(
    .WIDTH  (WIDTH),
    .NUM_CH (NUM_CH),
    .ACC_W  (ACC_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .clr      (clr),
    .i_data_i (i_data_i),
    .i_data_w (i_data_w),
    .o_bit    (o_bit),
    .o_sign   (o_sign),
    .o_busy   (o_busy),
    .o_done   (o_done)
`ifdef UTEMP_ACC_EN
    ,
    .o_acc    (o_acc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  typedef struct {
    logic [7:0]  di;
    logic [31:0] dw;
    logic [31:0] cnt;    // {c3,c2,c1,c0}, 8 bits each
    logic [3:0]  sign;
    logic [3:0]  first;
  } vec_t;

  vec_t vec [6];

  int         cnt [4];
  int         run_len;
  logic       done_seen;
  logic       sign_stable;
  logic [3:0] sign_seen;
  logic [3:0] first_bits;
  logic [3:0] last_bits;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observe one period starting at the first RUN sample, stop on DONE.
  task automatic measure();
    for (int c = 0; c < 4; c++) cnt[c] = 0;
    run_len     = 0;
    sign_seen   = o_sign;
    sign_stable = 1'b1;
    first_bits  = o_bit;
    last_bits   = '0;
    while (!o_done && run_len < 400) begin
      if (o_busy) begin
        for (int c = 0; c < 4; c++) if (o_bit[c]) cnt[c]++;
        last_bits = o_bit;
      end
      if (o_sign !== sign_seen) sign_stable = 1'b0;
      run_len++;
      tick();
    end
    done_seen = o_done;
  endtask

  task automatic run_period(input logic [7:0] di, input logic [31:0] dw);
    i_data_i = di;
    i_data_w = dw;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    measure();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((o_busy || o_done) && n < 300) begin
      tick();
      n++;
    end
    chk(name, int'(o_busy | o_done), 0);
  endtask

  int done_idx [4];
  int ones_per [4];
  int nd;
  int ones_cur;
  int npulse;

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    clr      = 1'b0;
    i_data_i = '0;
    i_data_w = '0;

    vec[0] = '{8'h40, 32'hA07F0040, {8'd16, 8'd64,  8'd0,   8'd32},  4'b1000, 4'b1101};
    vec[1] = '{8'h7F, 32'h01FF007F, {8'd1,  8'd127, 8'd0,   8'd127}, 4'b0100, 4'b1101};
    vec[2] = '{8'h00, 32'hFF7F7F7F, {8'd0,  8'd0,   8'd0,   8'd0},   4'b1000, 4'b0000};
    vec[3] = '{8'h80, 32'hFF00857F, {8'd0,  8'd0,   8'd0,   8'd0},   4'b0101, 4'b0000};
    vec[4] = '{8'h81, 32'h4081007F, {8'd1,  8'd1,   8'd0,   8'd1},   4'b1011, 4'b1101};
    vec[5] = '{8'h64, 32'hE020FF40, {8'd75, 8'd25,  8'd100, 8'd50},  4'b1010, 4'b1111};

    repeat (3) tick();
    chk("reset_outputs", int'({o_bit, o_sign, o_busy, o_done}), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", int'({o_busy, o_done}), 0);

    // Table-driven periods
    for (int v = 0; v < 6; v++) begin
      run_period(vec[v].di, vec[v].dw);
      chk($sformatf("v%0d_done", v), int'(done_seen), 1);
      chk($sformatf("v%0d_run_len", v), run_len, P);
      for (int c = 0; c < 4; c++) begin
        logic [31:0] e;
        e = vec[v].cnt;
        chk($sformatf("v%0d_ones_ch%0d", v, c), cnt[c], int'(e[c*8 +: 8]));
      end
      chk($sformatf("v%0d_sign", v), int'(o_sign), int'(vec[v].sign));
      chk($sformatf("v%0d_sign_stable", v), int'(sign_stable), 1);
      chk($sformatf("v%0d_first_bits", v), int'(first_bits), int'(vec[v].first));
      chk($sformatf("v%0d_last_bits", v), int'(last_bits), 0);
      chk($sformatf("v%0d_busy_in_done", v), int'(o_busy), 0);
      tick();
      chk($sformatf("v%0d_done_single", v), int'(o_done), 0);
      chk($sformatf("v%0d_sign_cleared", v), int'(o_sign), 0);
    end

    // Start held high: back-to-back periods, mid-period input change ignored
    i_data_i = 8'h40;
    i_data_w = 32'h00000040;
    start    = 1'b1;
    tick();
    nd       = 0;
    ones_cur = 0;
    for (int n = 0; n < 300; n++) begin
      if (n == 10) i_data_i = 8'h00;
      if (n == 129) chk("b2b_idle_gap_busy", int'(o_busy), 0);
      if (o_bit[0]) ones_cur++;
      if (o_done) begin
        if (nd < 4) begin
          done_idx[nd] = n;
          ones_per[nd] = ones_cur;
        end
        nd++;
        ones_cur = 0;
      end
      tick();
    end
    start = 1'b0;
    chk("b2b_done_count", nd, 2);
    chk("b2b_first_done", done_idx[0], P);
    chk("b2b_spacing", done_idx[1] - done_idx[0], P + 2);
    chk("b2b_ones_p1", ones_per[0], 32);
    chk("b2b_ones_p2", ones_per[1], 0);
    wait_idle("b2b_wait_idle");

    // clr with start in IDLE: stays idle
    i_data_i = 8'h7F;
    i_data_w = 32'h0000007F;
    start    = 1'b1;
    clr      = 1'b1;
    tick();
    start    = 1'b0;
    clr      = 1'b0;
    chk("clr_start_idle", int'({o_busy, o_done, o_sign}), 0);
    tick();
    chk("clr_start_still_idle", int'({o_busy, o_bit}), 0);

    // clr at t=50: abort with no done pulse
    i_data_w = 32'hFF00007F;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (50) tick();
    chk("pre_clr_busy", int'(o_busy), 1);
    chk("pre_clr_sign", int'(o_sign), 4'b1000);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_abort", int'({o_bit, o_sign, o_busy, o_done}), 0);
    npulse = 0;
    for (int n = 0; n < 140; n++) begin
      if (o_done || o_busy) npulse++;
      tick();
    end
    chk("clr_no_done", npulse, 0);

    // rst_n at t=20: outputs drop immediately
    i_data_w = 32'h0000007F;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    repeat (20) tick();
    chk("pre_rst_bit0", int'(o_bit[0]), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", int'({o_bit, o_sign, o_busy, o_done}), 0);
    tick();
    rst_n = 1'b1;
    npulse = 0;
    for (int n = 0; n < 140; n++) begin
      if (o_done || o_busy) npulse++;
      tick();
    end
    chk("rst_no_done", npulse, 0);

`ifdef UTEMP_ACC_EN
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("acc_clr0", int'($signed(o_acc[5:0])), 0);
    run_period(8'h7F, 32'h0000007F);
    tick();
    chk("acc_sat_pos_p1", int'($signed(o_acc[5:0])), 31);
    chk("acc_ch1_zero", int'($signed(o_acc[11:6])), 0);
    run_period(8'h7F, 32'h0000007F);
    tick();
    chk("acc_sat_pos_p2", int'($signed(o_acc[5:0])), 31);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("acc_clr1", int'($signed(o_acc[5:0])), 0);
    run_period(8'h7F, 32'h000000FF);
    tick();
    chk("acc_sat_neg", int'($signed(o_acc[5:0])), -32);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("acc_clr2", int'($signed(o_acc[5:0])), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
